// File: rtl/rare_stream_pkg.sv
// rare_stream_pkg: shared FSM state type and default FIFO depth for the
// rare_sram_streamer burst engine.
package rare_stream_pkg;

  localparam int RFIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rare_stream_fifo.sv
// rare_stream_fifo: synchronous read-return FIFO, head visible on dout,
// async active-low reset flushes pointers and count (storage is not cleared).
module rare_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // storage write; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rare_sram_streamer.sv
// rare_sram_streamer: burst read/write streamer in front of a single-port
// SRAM mux. Reads are credit-limited so the return FIFO can never overflow.
// Optional macro RARE_STREAM_CHKSUM_EN adds a running XOR checksum output.
module rare_sram_streamer
  import rare_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_STEP   = 1,
  parameter int RFIFO_DEPTH = RFIFO_DEPTH_DEF
) (
  input  logic                  stream_clk,
  input  logic                  stream_rst_n,
  input  logic                  stream_enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [31:0]           stream_addr,
  output logic [DATA_WIDTH-1:0] stream_data_in,
  output logic                  stream_we,
  output logic                  stream_en,
  input  logic [DATA_WIDTH-1:0] stream_data_out,
  output logic                  busy,
`ifdef RARE_STREAM_CHKSUM_EN
  output logic [DATA_WIDTH-1:0] chksum,
`endif
  output logic                  done
);

  localparam int AW = $clog2(RFIFO_DEPTH);

  state_e        state;
  logic [31:0]   addr;
  logic [15:0]   cnt;
  logic          done_r;
  // [0]: read request on the SRAM port this cycle, [1]: its data is on stream_data_out
  logic [1:0]    vld_pipe;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic [1:0]    inflight;
  logic [31:0]   occ;
  logic          cmd_hs, wr_issue, rd_issue, push, pop, last_push;

  assign inflight  = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
  assign occ       = 32'(fifo_count) + 32'(inflight);
  assign cmd_hs    = (state == ST_IDLE) && cmd_valid;
  assign wr_issue  = (state == ST_WRITE) && stream_enable && wdata_valid;
  assign rd_issue  = (state == ST_READ) && stream_enable && (occ < 32'(RFIFO_DEPTH));
  assign push      = vld_pipe[1];
  assign pop       = rdata_valid && rdata_ready;
  // final read word is being pushed when nothing else remains behind it
  assign last_push = (state == ST_DRAIN) && vld_pipe[1] && !vld_pipe[0];

  assign cmd_ready   = (state == ST_IDLE);
  assign wdata_ready = (state == ST_WRITE) && stream_enable;
  assign rdata_valid = !fifo_empty;
  assign busy        = (state != ST_IDLE) || (vld_pipe != 2'b00);
  assign done        = done_r || last_push;

  // burst FSM, SRAM request register and read-latency tracking
  always_ff @(posedge stream_clk or negedge stream_rst_n) begin
    if (!stream_rst_n) begin
      state          <= ST_IDLE;
      addr           <= '0;
      cnt            <= '0;
      done_r         <= 1'b0;
      vld_pipe       <= '0;
      stream_en      <= 1'b0;
      stream_we      <= 1'b0;
      stream_addr    <= '0;
      stream_data_in <= '0;
    end else begin
      done_r    <= 1'b0;
      stream_en <= 1'b0;
      stream_we <= 1'b0;
      vld_pipe  <= {vld_pipe[0], rd_issue};
      unique case (state)
        ST_IDLE: if (cmd_valid) begin
          addr <= cmd_addr;
          cnt  <= cmd_len;
          if (cmd_len == 16'd0) done_r <= 1'b1;
          else                  state  <= cmd_write ? ST_WRITE : ST_READ;
        end
        ST_WRITE: if (wr_issue) begin
          stream_en      <= 1'b1;
          stream_we      <= 1'b1;
          stream_addr    <= addr;
          stream_data_in <= wdata;
          addr           <= addr + 32'(ADDR_STEP);
          cnt            <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state  <= ST_IDLE;
            done_r <= 1'b1;
          end
        end
        ST_READ: if (rd_issue) begin
          stream_en   <= 1'b1;
          stream_addr <= addr;
          addr        <= addr + 32'(ADDR_STEP);
          cnt         <= cnt - 16'd1;
          if (cnt == 16'd1) state <= ST_DRAIN;
        end
        ST_DRAIN: if (last_push) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RARE_STREAM_CHKSUM_EN
  // XOR of every written and every FIFO-pushed word, restarted per command
  always_ff @(posedge stream_clk or negedge stream_rst_n) begin
    if (!stream_rst_n)  chksum <= '0;
    else if (cmd_hs)    chksum <= '0;
    else                chksum <= chksum ^ (wr_issue ? wdata : '0)
                                         ^ (push ? stream_data_out : '0);
  end
`endif

  rare_stream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RFIFO_DEPTH)
  ) u_rfifo (
    .clk   (stream_clk),
    .rst_n (stream_rst_n),
    .push  (push),
    .din   (stream_data_out),
    .pop   (pop),
    .dout  (rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_rare_sram_streamer.sv
// tb_rare_sram_streamer: directed bench with a small SRAM model and access/
// read/done monitors; expected values are hand-derived per test.
module tb_rare_sram_streamer;

  logic        clk, rst_n, stream_enable;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic [31:0] stream_addr, stream_data_in, stream_data_out;
  logic        stream_we, stream_en, busy, done;

  rare_sram_streamer dut (
    .stream_clk(clk), .stream_rst_n(rst_n), .stream_enable(stream_enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .stream_addr(stream_addr), .stream_data_in(stream_data_in),
    .stream_we(stream_we), .stream_en(stream_en),
    .stream_data_out(stream_data_out), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: one-cycle read latency, indexed by the low address byte
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (stream_en && stream_we)  mem[stream_addr[7:0]] <= stream_data_in;
    if (stream_en && !stream_we) stream_data_out <= mem[stream_addr[7:0]];
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        dn;
    int          cyc;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] rd_q[$];
  int          done_cnt, done_cyc, cyc;
  int          n_cmp, n_bad;

  always @(posedge clk) cyc <= cyc + 1;

  // monitors sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (stream_en) log_q.push_back('{stream_we, stream_addr, stream_data_in, done, cyc});
    if (rdata_valid && rdata_ready) rd_q.push_back(rdata);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    log_q.delete();
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [15:0] l);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr_beats(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      int k = 0;
      @(negedge clk);
      while (!wdata_ready && k < 50) begin @(negedge clk); k++; end
      if (!wdata_ready) chk("wdata_ready_timeout", wdata_ready, 1);
      wdata_valid = 1'b1;
      wdata = base + i;
      @(posedge clk);
    end
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy && k < budget);
    chk({tag, "_idle"}, busy, 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
    rst_n = 1'b0; stream_enable = 1'b1; rdata_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;

    // reset values
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_stream_en", stream_en, 0);
    chk("rst_stream_we", stream_we, 0);
    chk("rst_stream_addr", stream_addr, 0);
    chk("rst_stream_data_in", stream_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    // write 0x10 x3: A, B, C; done with the third access
    clr();
    send_cmd(1'b1, 32'h10, 16'd3);
    wr_beats(32'hAAAA_0000, 3);
    wait_idle("wr3", 50);
    chk("wr3_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      chk("wr3_we", log_q[i].we, 1);
      chk("wr3_addr", log_q[i].a, 32'h10 + i);
      chk("wr3_data", log_q[i].d, 32'hAAAA_0000 + i);
      chk("wr3_done_align", log_q[i].dn, (i == 2));
    end
    chk("wr3_done_cnt", done_cnt, 1);

    // read them back; done on the cycle the last word is pushed
    clr();
    send_cmd(1'b0, 32'h10, 16'd3);
    wait_idle("rd3", 50);
    chk("rd3_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      chk("rd3_we", log_q[i].we, 0);
      chk("rd3_addr", log_q[i].a, 32'h10 + i);
    end
    chk("rd3_words", rd_q.size(), 3);
    for (int i = 0; i < 3 && i < rd_q.size(); i++) chk("rd3_rdata", rd_q[i], 32'hAAAA_0000 + i);
    chk("rd3_done_cnt", done_cnt, 1);
    if (log_q.size() == 3) chk("rd3_done_cycle", done_cyc - log_q[2].cyc, 1);

    // prime 0x20..0x27, then read 8 with the consumer stalled
    clr();
    send_cmd(1'b1, 32'h20, 16'd8);
    wr_beats(32'h1000_0000, 8);
    wait_idle("prime", 50);
    clr();
    rdata_ready = 1'b0;
    send_cmd(1'b0, 32'h20, 16'd8);
    repeat (20) @(negedge clk);
    chk("rd8_issue_cap", log_q.size(), 4);
    chk("rd8_head_valid", rdata_valid, 1);
    chk("rd8_head", rdata, 32'h1000_0000);
    chk("rd8_busy", busy, 1);
    chk("rd8_no_done", done_cnt, 0);
    rdata_ready = 1'b1;
    wait_idle("rd8", 100);
    chk("rd8_count", log_q.size(), 8);
    chk("rd8_words", rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++) chk("rd8_rdata", rd_q[i], 32'h1000_0000 + i);
    chk("rd8_done_cnt", done_cnt, 1);

    // address wrap
    clr();
    send_cmd(1'b1, 32'hFFFF_FFFF, 16'd2);
    wr_beats(32'hBEEF_0000, 2);
    wait_idle("wrap", 50);
    chk("wrap_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("wrap_addr0", log_q[0].a, 32'hFFFF_FFFF);
      chk("wrap_addr1", log_q[1].a, 32'h0000_0000);
    end

    // empty burst
    clr();
    send_cmd(1'b1, 32'h30, 16'd0);
    chk("len0_done", done, 1);
    repeat (5) @(negedge clk);
    chk("len0_no_access", log_q.size(), 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_busy", busy, 0);

    // stream_enable dropped for 5 cycles after the first read issues
    clr();
    send_cmd(1'b0, 32'h20, 16'd4);
    @(negedge clk);
    stream_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_issues", log_q.size(), 1);
    chk("stall_inflight_done", rd_q.size(), 1);
    chk("stall_busy", busy, 1);
    stream_enable = 1'b1;
    wait_idle("stall", 100);
    chk("stall_count", log_q.size(), 4);
    chk("stall_words", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("stall_rdata", rd_q[i], 32'h1000_0000 + i);
    chk("stall_done_cnt", done_cnt, 1);

    // reset in the middle of a write burst
    clr();
    send_cmd(1'b1, 32'h40, 16'd4);
    wr_beats(32'h7777_0000, 2);
    #2;
    chk("mid_pre_en", stream_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", stream_en, 0);
    chk("mid_rst_we", stream_we, 0);
    chk("mid_rst_addr", stream_addr, 0);
    chk("mid_rst_data", stream_data_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wready", wdata_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    clr();
    send_cmd(1'b1, 32'h50, 16'd1);
    wr_beats(32'h5555_0000, 1);
    wait_idle("post", 50);
    chk("post_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("post_addr", log_q[0].a, 32'h50);
      chk("post_data", log_q[0].d, 32'h5555_0000);
      chk("post_done_align", log_q[0].dn, 1);
    end
    chk("post_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rare_sram_streamer.md
RARE_SRAM_STREAMER -- requirements
Module: rare_sram_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning SRAM word width.
REQ-002 SHALL have parameter ADDR_STEP, default 1, meaning the address increment per burst beat.
REQ-003 SHALL have parameter RFIFO_DEPTH, default 4, meaning the read-return FIFO depth (power of 2, at least 4).
REQ-004 stream_clk  in  1  sole clock; the block has one clock and asynchronous active-low reset.
REQ-005 stream_rst_n  in  1  asynchronous active-low reset.
REQ-006 stream_enable  in  1  SRAM ownership granted to the stream side; no access issues while low.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  burst command handshake.
REQ-008 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  32  start address.
REQ-010 cmd_len  in  16  beat count; 0 = empty burst.
REQ-011 wdata_valid / wdata_ready / wdata  in / out / in  1 / 1 / DATA_WIDTH  write-data handshake.
REQ-012 rdata_valid / rdata_ready / rdata  out / in / out  1 / 1 / DATA_WIDTH  read-data handshake.
REQ-013 stream_addr, stream_data_in, stream_we, stream_en  out  32, DATA_WIDTH, 1, 1  SRAM request toward the memory mux.
REQ-014 stream_data_out  in  DATA_WIDTH  SRAM read data, valid the cycle after the read request.
REQ-015 busy  out  1  a burst is active or data is in flight.
REQ-016 done  out  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ and DRAIN.
REQ-018 IDLE: cmd_ready=1; on a cmd handshake, the block SHALL latch addr and len and go to WRITE or READ per cmd_write.
REQ-019 A command with cmd_len=0 SHALL pulse done the next cycle, stay in IDLE and issue no SRAM access.
REQ-020 WRITE: wdata_ready SHALL equal stream_enable; each wdata handshake SHALL register stream_en=1, stream_we=1, stream_addr=current addr and stream_data_in=wdata for exactly the next cycle.
REQ-021 READ: a beat SHALL issue (stream_en=1, stream_we=0, registered) only when stream_enable=1 and fifo_count + inflight < RFIFO_DEPTH.
REQ-022 Read data SHALL be pushed into the FIFO from stream_data_out two cycles after the issue decision (request cycle + 1).
REQ-023 After each issued beat, addr SHALL advance by ADDR_STEP with modulo-2^32 wrap (0xFFFFFFFF + 1 = 0x00000000), and the remaining count SHALL decrement.
REQ-024 After the last write beat issues, the block SHALL return to IDLE and pulse done in the same cycle as the final stream_en.
REQ-025 After the last read issues, the block SHALL enter DRAIN, pulse done when the final word is pushed into the FIFO, then return to IDLE.
REQ-026 stream_enable falling mid-burst SHALL pause issue with state, addr and count held; in-flight reads still complete into the FIFO.
REQ-027 rdata SHALL be the FIFO head, with rdata_valid = FIFO not empty; a push and pop in the same cycle SHALL leave the count unchanged.
REQ-028 Outside issue cycles, stream_en=0 and stream_we=0; stream_addr and stream_data_in SHALL hold their last values.
REQ-029 busy = (state != IDLE) or inflight != 0.

Reset
REQ-030 On stream_rst_n low, the block SHALL go asynchronously to IDLE, flush the FIFO, and clear inflight, addr and count.
REQ-031 Reset values SHALL be: cmd_ready=1 after release; wdata_ready=0, rdata_valid=0, stream_en=0, stream_we=0, stream_addr=0, stream_data_in=0, busy=0, done=0.
REQ-032 Reset mid-burst SHALL abandon the burst without emitting done.

Configuration
REQ-033 Macro RARE_STREAM_CHKSUM_EN defined: the block SHALL add output chksum [DATA_WIDTH-1:0], the XOR of every written or FIFO-pushed word, cleared on a cmd handshake and on reset.
REQ-034 Macro RARE_STREAM_CHKSUM_EN undefined: the chksum port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-035 Package rare_stream_pkg SHALL hold the state enum and the RFIFO_DEPTH default.
REQ-036 The read FIFO SHALL be sub-module rare_stream_fifo, a synchronous FIFO with async reset and count output.

Verification
REQ-037 Write addr=0x10, len=3, data A,B,C, stream_enable=1 -> stream_en/we high at 0x10, 0x11, 0x12 with A, B, C; done coincides with the third access.
REQ-038 Read addr=0x10, len=3 after REQ-037, rdata_ready=1 -> rdata A, B, C in order; done on the third push; busy drops after.
REQ-039 Read len=8 with rdata_ready=0 -> at most 4 issues; issue resumes only when rdata_ready rises; no word is lost.
REQ-040 Write addr=0xFFFFFFFF, len=2 -> accesses at 0xFFFFFFFF then 0x00000000.
REQ-041 cmd_len=0 -> done after 1 cycle, stream_en never asserted; stream_enable dropped for 5 cycles mid-read -> issue stalls, then completes correctly.
REQ-042 Assert stream_rst_n low mid-write -> outputs take reset values immediately; no done; a fresh command afterwards works.
